// File: rtl/svi_scalar_reader_if.sv
// Bundle between the member writer / read requester and svi_scalar_reader.
// The slave modport is the read-only view the reader consumes.
interface svi_scalar_reader_if #(
  parameter int CNT_W = 8
);
  logic             i_z;
  logic             i_y;
  logic             i_x;
  logic             i_rd_req;
  logic [1:0]       i_rd_sel;
  logic             o_rd_ack;
  logic [CNT_W-1:0] o_rd_data;
  logic             o_rd_err;
  logic [2:0]       o_change;
  logic [2:0]       o_sat;

  modport master (
    output i_z, i_y, i_x, i_rd_req, i_rd_sel,
    input  o_rd_ack, o_rd_data, o_rd_err, o_change, o_sat
  );

  modport slave (
    input  i_z, i_y, i_x, i_rd_req, i_rd_sel,
    output o_rd_ack, o_rd_data, o_rd_err, o_change, o_sat
  );
endinterface

// File: rtl/svi_scalar_reader.sv
// Monitor for the scalar members z/y/x: per-member change pulses, saturating
// read-to-clear change counters and a req/ack readout port.
module svi_scalar_reader #(
  parameter int CNT_W = 8
) (
  input  logic                i_clk,
  input  logic                i_srst,
  svi_scalar_reader_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  state_t           state;
  logic [2:0]       r_cur;
  logic [2:0]       r_prev;
  logic             primed;
  logic             primed_d;
  logic [2:0]       change_q;
  logic [CNT_W-1:0] cnt [3];
  logic [2:0]       sat_q;
  logic             ack_q;
  logic             err_q;
  logic [CNT_W-1:0] data_q;

  logic             cap;
  logic [CNT_W-1:0] sel_cnt;

  // Capture happens on any IDLE cycle with a request present
  assign cap = (state == IDLE) && bus.i_rd_req;

  // Select the counter addressed by the incoming request; select 3 reads 0
  always_comb begin
    sel_cnt = '0;
    case (bus.i_rd_sel)
      2'd0:    sel_cnt = cnt[0];
      2'd1:    sel_cnt = cnt[1];
      2'd2:    sel_cnt = cnt[2];
      default: sel_cnt = '0;
    endcase
  end

  // Sample members and form registered change pulses; primed_d masks the
  // spurious edge between the reset value and the first real sample
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_cur    <= '0;
      r_prev   <= '0;
      primed   <= 1'b0;
      primed_d <= 1'b0;
      change_q <= '0;
    end else begin
      r_cur    <= {bus.i_x, bus.i_y, bus.i_z};
      r_prev   <= r_cur;
      primed   <= 1'b1;
      primed_d <= primed;
      change_q <= (r_cur ^ r_prev) & {3{primed_d}};
    end
  end

  // Saturating counters with sticky saturation flags, cleared by a capture
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      for (int unsigned i = 0; i < 3; i++) cnt[i] <= '0;
      sat_q <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (cap && (bus.i_rd_sel == 2'(i))) begin
          // A pulse coinciding with the capture is kept as the new count
          cnt[i]   <= change_q[i] ? CNT_ONE : '0;
          sat_q[i] <= change_q[i] && (CNT_ONE == CNT_MAX);
        end else if (change_q[i]) begin
          if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CNT_ONE;
          if (cnt[i] >= CNT_MAX - CNT_ONE) sat_q[i] <= 1'b1;
        end
      end
    end
  end

  // Read FSM: capture in IDLE, one-cycle registered response in RESP
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state  <= IDLE;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack_q  <= 1'b0;
          err_q  <= 1'b0;
          data_q <= '0;
          if (bus.i_rd_req) begin
            state  <= RESP;
            ack_q  <= 1'b1;
            err_q  <= (bus.i_rd_sel == 2'd3);
            data_q <= sel_cnt;
          end
        end
        default: begin
          state  <= IDLE;
          ack_q  <= 1'b0;
          err_q  <= 1'b0;
          data_q <= '0;
        end
      endcase
    end
  end

  assign bus.o_rd_ack  = ack_q;
  assign bus.o_rd_err  = err_q;
  assign bus.o_rd_data = data_q;
  assign bus.o_change  = change_q;
  assign bus.o_sat     = sat_q;

endmodule

// File: tb/tb_svi_scalar_reader.sv
// Directed bench for svi_scalar_reader: one CNT_W=8 and one CNT_W=2 instance.
module tb_svi_scalar_reader;

  logic clk = 1'b0;
  logic srst;
  int   vectors = 0;
  int   miscompares = 0;
  int   acks;

  always #5 clk = ~clk;

  svi_scalar_reader_if #(.CNT_W(8)) bus8 ();
  svi_scalar_reader_if #(.CNT_W(2)) bus2 ();

  svi_scalar_reader #(.CNT_W(8)) dut8 (.i_clk(clk), .i_srst(srst), .bus(bus8));
  svi_scalar_reader #(.CNT_W(2)) dut2 (.i_clk(clk), .i_srst(srst), .bus(bus2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd8(input logic [1:0] sel, input logic [7:0] exp_d,
                     input logic exp_e, input string tag);
    bus8.i_rd_req = 1'b1;
    bus8.i_rd_sel = sel;
    tick();
    bus8.i_rd_req = 1'b0;
    chk({tag, "_ack"}, 16'(bus8.o_rd_ack), 16'd1);
    chk({tag, "_data"}, 16'(bus8.o_rd_data), 16'(exp_d));
    chk({tag, "_err"}, 16'(bus8.o_rd_err), 16'(exp_e));
    tick();
    chk({tag, "_ackdrop"}, 16'(bus8.o_rd_ack), 16'd0);
  endtask

  task automatic rd2(input logic [1:0] sel, input logic [1:0] exp_d, input string tag);
    bus2.i_rd_req = 1'b1;
    bus2.i_rd_sel = sel;
    tick();
    bus2.i_rd_req = 1'b0;
    chk({tag, "_ack"}, 16'(bus2.o_rd_ack), 16'd1);
    chk({tag, "_data"}, 16'(bus2.o_rd_data), 16'(exp_d));
    tick();
  endtask

  initial begin
    srst = 1'b1;
    bus8.i_z = 1'b1; bus8.i_y = 1'b1; bus8.i_x = 1'b1;
    bus8.i_rd_req = 1'b0; bus8.i_rd_sel = 2'd0;
    bus2.i_z = 1'b0; bus2.i_y = 1'b0; bus2.i_x = 1'b0;
    bus2.i_rd_req = 1'b0; bus2.i_rd_sel = 2'd0;
    repeat (3) tick();

    // Reset state
    chk("rst_ack", 16'(bus8.o_rd_ack), 16'd0);
    chk("rst_data", 16'(bus8.o_rd_data), 16'd0);
    chk("rst_err", 16'(bus8.o_rd_err), 16'd0);
    chk("rst_change", 16'(bus8.o_change), 16'd0);
    chk("rst_sat", 16'(bus8.o_sat), 16'd0);
    chk("rst_sat2", 16'(bus2.o_sat), 16'd0);

    // Inputs held at 1 through reset must not produce change pulses
    srst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("prime_change", 16'(bus8.o_change), 16'd0);
    end
    rd8(2'd0, 8'd0, 1'b0, "prime_rd_z");
    rd8(2'd1, 8'd0, 1'b0, "prime_rd_y");
    rd8(2'd2, 8'd0, 1'b0, "prime_rd_x");

    // Five y toggles: sampled at edges 0..4, pulses after edges 1..5
    for (int i = 0; i < 8; i++) begin
      if (i < 5) bus8.i_y = ~bus8.i_y;
      tick();
      chk("y_change", 16'(bus8.o_change), (i >= 1 && i <= 5) ? 16'b010 : 16'b000);
    end
    rd8(2'd1, 8'd5, 1'b0, "y_rd");
    rd8(2'd1, 8'd0, 1'b0, "y_reread");

    // Narrow counter saturates at 3
    for (int i = 0; i < 9; i++) begin
      if (i < 6) bus2.i_x = ~bus2.i_x;
      tick();
    end
    chk("sat2_set", 16'(bus2.o_sat), 16'b100);
    rd2(2'd2, 2'd3, "sat2_rd");
    chk("sat2_clr", 16'(bus2.o_sat), 16'b000);

    // z counter to 4, then a fifth pulse on the capture edge
    for (int i = 0; i < 6; i++) begin
      if (i < 4) bus8.i_z = ~bus8.i_z;
      tick();
    end
    bus8.i_z = ~bus8.i_z;
    tick();
    tick();
    chk("z_pulse_at_cap", 16'(bus8.o_change), 16'b001);
    rd8(2'd0, 8'd4, 1'b0, "z_cap_rd");
    rd8(2'd0, 8'd1, 1'b0, "z_after_rd");

    // x counter to 2, then a held invalid-select request
    for (int i = 0; i < 5; i++) begin
      if (i < 2) bus8.i_x = ~bus8.i_x;
      tick();
    end
    acks = 0;
    bus8.i_rd_req = 1'b1;
    bus8.i_rd_sel = 2'd3;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus8.o_rd_ack) acks++;
      chk("inv_ack", 16'(bus8.o_rd_ack), 16'((i % 2) == 0));
      chk("inv_err", 16'(bus8.o_rd_err), 16'((i % 2) == 0));
      chk("inv_data", 16'(bus8.o_rd_data), 16'd0);
    end
    bus8.i_rd_req = 1'b0;
    tick();
    chk("inv_ack_count", 16'(acks), 16'd3);
    rd8(2'd2, 8'd2, 1'b0, "inv_x_kept");

    // Reset arriving during RESP
    for (int i = 0; i < 7; i++) begin
      if (i < 4) bus2.i_x = ~bus2.i_x;
      if (i < 2) bus8.i_x = ~bus8.i_x;
      tick();
    end
    chk("sat2_again", 16'(bus2.o_sat), 16'b100);
    bus8.i_rd_req = 1'b1;
    bus8.i_rd_sel = 2'd1;
    tick();
    chk("mid_rst_resp", 16'(bus8.o_rd_ack), 16'd1);
    bus8.i_rd_req = 1'b0;
    srst = 1'b1;
    tick();
    chk("mid_rst_noack", 16'(bus8.o_rd_ack), 16'd0);
    chk("mid_rst_sat2", 16'(bus2.o_sat), 16'b000);
    srst = 1'b0;
    tick();
    rd8(2'd0, 8'd0, 1'b0, "post_rst_z");
    rd8(2'd1, 8'd0, 1'b0, "post_rst_y");
    rd8(2'd2, 8'd0, 1'b0, "post_rst_x");
    rd2(2'd2, 2'd0, "post_rst_x2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/svi_scalar_reader.md
Name: svi_scalar_reader

Overview:
- Reader end for a scalar-member interface. Another block writes the 1-bit members z, y and x of an interface instance from `always_ff`; this block samples them once per cycle through a read-only modport.
- Detects value changes on each member and keeps a saturating read-to-clear change counter per member.
- Counters are read out over a req/ack handshake.
- Sits beside the writer, on the same clock, as its monitor/consumer.

Parameters:
- CNT_W, 8, width of each per-member change counter (legal range 2..16).

Ports:
- i_clk  input  1  clock; all logic on the rising edge.
- i_srst  input  1  reset, synchronous, active-high.
- i_z  input  1  member z of the interface instance, via read-only modport.
- i_y  input  1  member y, via modport.
- i_x  input  1  member x, via modport.
- i_rd_req  input  1  read request, level-sampled in IDLE only.
- i_rd_sel  input  2  counter select: 0=z, 1=y, 2=x, 3=invalid.
- o_rd_ack  output  1  one-cycle response strobe.
- o_rd_data  output  CNT_W  selected counter value; valid only while o_rd_ack=1, otherwise 0.
- o_rd_err  output  1  set with o_rd_ack when the captured select was 3.
- o_change  output  3  per-member change pulse, {x,y,z}.
- o_sat  output  3  sticky per-member saturation flag, {x,y,z}.

Behaviour:
- Reset values: all outputs 0, all counters 0, sample registers 0, primed flag 0, FSM in IDLE.
- Sampling:
  - Each edge registers {i_x,i_y,i_z} into r_cur, and the old r_cur into r_prev.
  - The primed flag sets on the first edge after reset deassertion.
  - change = (r_cur ^ r_prev) & {3{primed_d}}, where primed_d is primed delayed one cycle. This suppresses any change caused by the reset value of 0.
- Change latency:
  - An input that differs at edge N (sampled into r_cur) gives o_change high in the cycle after edge N+1.
  - The pulse lasts exactly one cycle per transition.
  - A member toggling every cycle gives o_change continuously high for that bit.
- Counters:
  - On each change pulse the counter increments by 1.
  - At 2^CNT_W-1 it holds, and the matching o_sat bit sets.
  - o_sat stays set until that counter is read or reset is applied.
- Read FSM:
  - IDLE: if i_rd_req=1, capture i_rd_sel and go to RESP.
  - The counter is cleared at the capture edge, and its value at that moment goes into the response register.
  - If the same member's change pulse is present on the capture edge, the counter becomes 1 rather than 0. The pre-increment value is the one returned.
  - The same member's o_sat bit clears on capture unless saturation re-occurs.
  - RESP: o_rd_ack=1 with o_rd_data for exactly one cycle, then IDLE unconditionally.
  - A request held high is re-accepted on the next IDLE cycle, so back-to-back reads give one ack every 2 cycles.
  - i_rd_req and i_rd_sel are ignored in RESP.
- Invalid select (3): in RESP, o_rd_ack=1, o_rd_err=1, o_rd_data=0. No counter is cleared.
- Reset mid-operation: i_srst in RESP forces IDLE and clears everything. o_rd_ack is 0 in the cycle after the reset edge.
- Reset has priority over all other events.
- All state, including sampling, is on the single clock; there is no synchronizer. The members are produced in the same clock domain.

Test Plan:
- Reset with i_z=i_y=i_x=1 held, then release → o_change stays 000 for 10 cycles; reading sel=0, 1 and 2 each returns data=0, err=0.
- After priming, toggle i_y 5 times, one cycle apart → o_change[1] pulses 5 times, each 2 edges after the input change; read sel=1 → ack one cycle later with data=5; an immediate re-read of sel=1 gives data=0.
- CNT_W=2; toggle i_x 6 times → counter 3, o_sat=100; read sel=2 → data=3, o_sat=000.
- Arrange an i_z change pulse on the same edge as a sel=0 capture, counter at 4 → data=4; a subsequent read gives data=1.
- Hold i_rd_req=1 with sel=3 for 6 cycles → exactly 3 acks, each with err=1 and data=0; all counters are unchanged.
- Assert i_srst in the RESP cycle → no ack in the next cycle; o_sat=000 and all counters read 0 afterwards.
